// File: rtl/acc_readout_pkg.sv
// Shared types and default widths for the accumulator readout / requantizer.
package acc_readout_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    SAT   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_ACC_W   = 16;
  localparam int DEF_OUT_W   = 8;
  localparam int DEF_SHIFT_W = 4;

  localparam int OUT_MAX = 2**(DEF_OUT_W-1) - 1;
  localparam int OUT_MIN = -(2**(DEF_OUT_W-1));

endpackage

// File: rtl/acc_readout_sat_clamp.sv
// Combinational ReLU + signed saturation from the scaled (ACC_W+1)-bit value
// down to the OUT_W-bit activation.
module sat_clamp
  import acc_readout_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W:0]   val,
  input  logic                    relu_en,
  output logic        [OUT_W-1:0] data,
  output logic                    sat
);

  localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(-(2**(OUT_W-1)));

  // ReLU zeroing takes priority and is not reported as saturation.
  always_comb begin
    data = '0;
    sat  = 1'b0;
    if (relu_en && val[ACC_W]) begin
      data = '0;
    end else if (val > HI) begin
      data = HI[OUT_W-1:0];
      sat  = 1'b1;
    end else if (val < LO) begin
      data = LO[OUT_W-1:0];
      sat  = 1'b1;
    end else begin
      data = val[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/acc_readout.sv
// Accumulator readout: captures a finished MAC result, applies a rounding
// arithmetic right shift, ReLU/saturation, and hands it off over valid/ready.
module acc_readout
  import acc_readout_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SHIFT_W = DEF_SHIFT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               acc_valid,
  output logic               acc_ready,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [SHIFT_W-1:0] shift,
  input  logic               relu_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               sat_flag,
  output logic               busy
);

  state_t state, state_nxt;

  logic        [ACC_W-1:0]   acc_q;
  logic        [SHIFT_W-1:0] shift_q;
  logic                      relu_q;
  logic signed [ACC_W:0]     scaled_q;

  logic signed [ACC_W:0]     rnd;
  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W:0]     scaled_d;
  logic        [OUT_W-1:0]   clamp_data;
  logic                      clamp_sat;

  // One extra bit of headroom so adding the half-LSB never wraps.
  always_comb begin
    rnd      = (shift_q == '0) ? '0
                               : ({{ACC_W{1'b0}}, 1'b1} << (shift_q - 1'b1));
    sum      = {acc_q[ACC_W-1], acc_q} + rnd;
    scaled_d = sum >>> shift_q;
  end

  sat_clamp #(
    .ACC_W(ACC_W),
    .OUT_W(OUT_W)
  ) u_sat_clamp (
    .val    (scaled_q),
    .relu_en(relu_q),
    .data   (clamp_data),
    .sat    (clamp_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        acc_ready = 1'b1;
        busy      = 1'b0;
        if (acc_valid) state_nxt = SCALE;
      end
      SCALE: state_nxt = SAT;
      SAT:   state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      scaled_q <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_valid) begin
            acc_q   <= acc_in;
            shift_q <= shift;
            relu_q  <= relu_en;
          end
        end
        SCALE: scaled_q <= scaled_d;
        SAT: begin
          out_data <= clamp_data;
          sat_flag <= clamp_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/acc_readout.md
Name: acc_readout

Overview:
Reads the 16-bit neuron accumulator once a MAC sequence finishes. Requantizes the value to a signed 8-bit activation: arithmetic right shift with rounding, optional ReLU, then saturation. The result goes to the next layer over a valid/ready handshake. Sits downstream of the bias-initialised accumulator register and returns the datapath to 8-bit width for the next neuron layer.

Parameters:
ACC_W, 16, accumulator width (two's complement)
OUT_W, 8, activation width (two's complement)
SHIFT_W, 4, width of the shift-amount input (0..2^SHIFT_W-1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
acc_valid  input  1  accumulator result available
acc_ready  output  1  block can accept a result
acc_in  input  ACC_W  signed accumulator value
shift  input  SHIFT_W  right-shift amount, sampled with acc_in
relu_en  input  1  clamp negatives to 0, sampled with acc_in
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  OUT_W  signed activation
sat_flag  output  1  the value on out_data was clipped by saturation
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. out_valid=0, out_data=0, sat_flag=0, busy=0, acc_ready=1 on the next cycle. Reset overrides every state, including HOLD with data pending; pending data is discarded.
- FSM states: IDLE, SCALE, SAT, HOLD.
- IDLE:
  - acc_ready=1.
  - On acc_valid=1, capture acc_in, shift and relu_en, then go to SCALE.
- SCALE:
  - Form r = sext(acc_in, ACC_W+1) + (shift==0 ? 0 : 1<<(shift-1)). This is round half up; the extra bit prevents overflow.
  - scaled = r >>> shift, arithmetic.
  - Register scaled at ACC_W+1 bits, then go to SAT.
- SAT:
  - If relu_en=1 and scaled<0, v=0.
  - Otherwise clamp v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_flag=1 only if the clamp changed the value. ReLU zeroing does not set sat_flag.
  - Register out_data and sat_flag, then go to HOLD.
- HOLD:
  - out_valid=1.
  - out_data and sat_flag stay stable while out_ready=0, with no limit on the wait.
  - On out_ready=1, the transfer completes and the FSM goes to IDLE. out_valid drops on the next cycle.
  - out_data keeps its last value after the transfer.
- acc_ready=0 in SCALE, SAT and HOLD. acc_valid in those states is ignored; the producer must hold it.
- Latency: accept edge at cycle 0, out_valid high from cycle 3. Minimum spacing between accepted results is 4 cycles, assuming out_ready is already high.
- out_ready without out_valid has no effect.
- shift and relu_en are used only at their sampled values; changing them mid-operation has no effect.

Decomposition:
- Shared package:
  - state enum (IDLE/SCALE/SAT/HOLD)
  - default widths ACC_W/OUT_W/SHIFT_W
  - constants OUT_MAX = 2^(OUT_W-1)-1 and OUT_MIN = -2^(OUT_W-1)
- One natural sub-module: sat_clamp, combinational. It takes an (ACC_W+1)-bit signed value and relu_en, and returns OUT_W data plus the saturation flag.
- The FSM, capture registers and rounding shift stay in acc_readout.

Test Plan:
- Rounding positive: acc_in=0x0123, shift=2, relu_en=0, out_ready=1 -> out_data=0x49, sat_flag=0, out_valid 3 cycles after accept.
- Saturation high: acc_in=0x7FFF, shift=0 -> out_data=0x7F, sat_flag=1. Then acc_in=0x7FFF, shift=15 -> out_data=0x01, sat_flag=0; this exercises the 17-bit rounding headroom.
- Negative values:
  - acc_in=0xFFFA (-6), shift=2, relu_en=0 -> out_data=0xFF.
  - acc_in=0xFF80, shift=0, relu_en=0 -> 0x80, sat_flag=0.
  - acc_in=0xFF80, shift=0, relu_en=1 -> 0x00, sat_flag=0.
  - acc_in=0x8000, shift=0, relu_en=0 -> 0x80, sat_flag=1.
- Backpressure: out_ready=0 for 6 cycles in HOLD -> out_valid=1, out_data and sat_flag constant, acc_ready=0, and acc_valid pulses are ignored. Raising out_ready -> one transfer, then IDLE.
- Back-to-back: acc_valid held high with acc_in=0x0010, 0x0020, shift=4, out_ready=1 -> out_data=0x01 then 0x02, accepts exactly 4 cycles apart.
- Reset mid-operation: assert rst while in SAT, and again while in HOLD -> next cycle out_valid=0, out_data=0, busy=0, acc_ready=1. A fresh transaction afterwards completes correctly.
